// File: rtl/tcdm_bank_responder.sv
// tcdm_bank_responder: memory-side responder for one TCDM bank.
// Handles byte-enabled writes, reads with RD_LATENCY cycles of latency,
// and atomic test-and-set (read old word, then set it to all ones).
// Optional per-byte even parity is built when TCDM_BANK_PARITY_EN is defined.
module tcdm_bank_responder #(
  parameter int DW             = 32,
  parameter int ADDR_MEM_WIDTH = 11,
  parameter int AW             = ADDR_MEM_WIDTH + 2,
  parameter int IW             = 20,
  parameter int RD_LATENCY     = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  output logic          gnt_o,
  input  logic [AW-1:0] add_i,
  input  logic          wen_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [DW-1:0] data_i,
  input  logic          ts_i,
  input  logic [IW-1:0] id_i,
`ifdef TCDM_BANK_PARITY_EN
  input  logic          err_inject_i,
  output logic          r_err_o,
`endif
  output logic          r_valid_o,
  output logic [DW-1:0] r_data_o,
  output logic [IW-1:0] r_id_o
);

  localparam int NB       = DW / 8;
  localparam int NB_WORDS = 2 ** ADDR_MEM_WIDTH;

  typedef enum logic {IDLE = 1'b0, TS_WR = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_MEM_WIDTH-1:0] ts_idx_q, ts_idx_d;
  logic [DW-1:0]             mem_q [NB_WORDS];

  logic [ADDR_MEM_WIDTH-1:0] idx;
  logic [1:0]                unused_addr;
  logic                      accept, rd_accept;
  logic                      wr_en;
  logic [ADDR_MEM_WIDTH-1:0] wr_idx;
  logic [NB-1:0]             wr_be;
  logic [DW-1:0]             wr_data;
  logic                      rd_err;

  assign idx         = add_i[AW-1:2];
  assign unused_addr = add_i[1:0];

  // Grant only in IDLE and never while reset is held.
  assign gnt_o     = (state_q == IDLE) && !rst_i;
  assign accept    = req_i && gnt_o;
  assign rd_accept = accept && wen_i;

  // Next-state logic and the single storage write port (port write or TS set).
  always_comb begin
    state_d  = state_q;
    ts_idx_d = ts_idx_q;
    wr_en    = 1'b0;
    wr_idx   = idx;
    wr_be    = be_i;
    wr_data  = data_i;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!wen_i) begin
            wr_en = 1'b1;
          end else if (ts_i) begin
            state_d  = TS_WR;
            ts_idx_d = idx;
          end
        end
      end
      TS_WR: begin
        state_d = IDLE;
        wr_en   = 1'b1;
        wr_idx  = ts_idx_q;
        wr_be   = '1;
        wr_data = '1;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and latched TS word index.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ts_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      ts_idx_q <= ts_idx_d;
    end
  end

  // Storage array; contents survive reset on purpose.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_be[k]) mem_q[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

`ifdef TCDM_BANK_PARITY_EN
  logic [NB-1:0] par_q [NB_WORDS];
  logic          wr_inj;

  // Injection applies only to port writes, never to the TS set cycle.
  assign wr_inj = (state_q == IDLE) && err_inject_i;

  // Even parity per byte, written alongside the data bytes.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_be[k]) par_q[wr_idx][k] <= (^wr_data[8*k +: 8]) ^ wr_inj;
      end
    end
  end

  // Flag a read when any byte disagrees with its stored parity.
  always_comb begin
    rd_err = 1'b0;
    for (int k = 0; k < NB; k++) begin
      rd_err = rd_err | ((^mem_q[idx][8*k +: 8]) ^ par_q[idx][k]);
    end
  end
`else
  assign rd_err = 1'b0;
`endif

  // Read pipeline: stage 0 samples the word at the accepting edge, the last
  // stage drives the response. Data stages load only with a valid so the
  // outputs hold their last response.
  logic [RD_LATENCY-1:0]         vld_q, vld_d;
  logic [RD_LATENCY-1:0]         err_q, err_d;
  logic [RD_LATENCY-1:0][DW-1:0] dat_q, dat_d;
  logic [RD_LATENCY-1:0][IW-1:0] id_q, id_d;

  // Shift valids every cycle; move payload only behind a valid.
  always_comb begin
    vld_d    = '0;
    err_d    = err_q;
    dat_d    = dat_q;
    id_d     = id_q;
    vld_d[0] = rd_accept;
    if (rd_accept) begin
      dat_d[0] = mem_q[idx];
      id_d[0]  = id_i;
      err_d[0] = rd_err;
    end
    for (int s = 1; s < RD_LATENCY; s++) begin
      vld_d[s] = vld_q[s-1];
      if (vld_q[s-1]) begin
        dat_d[s] = dat_q[s-1];
        id_d[s]  = id_q[s-1];
        err_d[s] = err_q[s-1];
      end
    end
  end

  // Pipeline registers; reset drops any in-flight response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      err_q <= '0;
      dat_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      dat_q <= dat_d;
      id_q  <= id_d;
    end
  end

  assign r_valid_o = vld_q[RD_LATENCY-1];
  assign r_data_o  = dat_q[RD_LATENCY-1];
  assign r_id_o    = id_q[RD_LATENCY-1];
`ifdef TCDM_BANK_PARITY_EN
  assign r_err_o   = vld_q[RD_LATENCY-1] & err_q[RD_LATENCY-1];
`endif

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Bench for tcdm_bank_responder: directed scenarios plus randomized traffic
// against a word-level memory model with an expected-response queue.
module tb_tcdm_bank_responder;

  localparam int LAT = 3;
`ifdef TCDM_BANK_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    int          cyc;
    logic [31:0] d;
    logic [19:0] id;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, wen = 1'b0, ts = 1'b0, inj = 1'b0;
  logic [12:0] add = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic [19:0] id = '0;
  logic        gnt, r_valid, r_err;
  logic [31:0] r_data;
  logic [19:0] r_id;

  int   cyc = 0, cmp = 0, errs = 0;
  rsp_t exp_q[$], got_q[$];
  logic [31:0] mem_m [int];
  logic [3:0]  bad_m [int];

  tcdm_bank_responder #(.DW(32), .ADDR_MEM_WIDTH(11), .AW(13), .IW(20), .RD_LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .add_i(add), .wen_i(wen),
    .be_i(be), .data_i(wdata), .ts_i(ts), .id_i(id),
`ifdef TCDM_BANK_PARITY_EN
    .err_inject_i(inj), .r_err_o(r_err),
`endif
    .r_valid_o(r_valid), .r_data_o(r_data), .r_id_o(r_id)
  );

`ifndef TCDM_BANK_PARITY_EN
  assign r_err = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every response with the cycle it was seen in.
  always @(negedge clk) begin : mon
    rsp_t r;
    if (r_valid === 1'b1) begin
      r.cyc = cyc; r.d = r_data; r.id = r_id; r.err = r_err;
      got_q.push_back(r);
    end
  end

  // Present one request, wait for its grant, and update the model.
  task automatic issue(input bit w, input bit t, input logic [12:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [19:0] i, input bit e, output int acc);
    int n = 0;
    int wi;
    logic [31:0] word;
    logic [3:0]  bad;
    rsp_t x;
    req = 1'b1; wen = w; ts = t; add = a; be = b; wdata = d; id = i; inj = e;
    while (gnt !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      cmp++; errs++;
      $display("FAIL grant_timeout: gnt=%b after %0d cycles, required 1", gnt, n);
    end
    @(posedge clk); #1;
    acc = cyc;
    req = 1'b0; inj = 1'b0;
    wi   = int'(a[12:2]);
    word = mem_m.exists(wi) ? mem_m[wi] : 32'h0;
    bad  = bad_m.exists(wi) ? bad_m[wi] : 4'h0;
    if (!w) begin
      for (int k = 0; k < 4; k++) if (b[k]) begin word[8*k +: 8] = d[8*k +: 8]; bad[k] = e; end
      mem_m[wi] = word; bad_m[wi] = bad;
    end else begin
      x.cyc = acc + LAT - 1; x.d = word; x.id = i; x.err = PAR ? |bad : 1'b0;
      exp_q.push_back(x);
      if (t) begin mem_m[wi] = 32'hFFFF_FFFF; bad_m[wi] = 4'h0; end
    end
  endtask

  task automatic drain();
    repeat (LAT + 3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    cmp++; if (gnt !== 1'b0) begin errs++; $display("FAIL reset_gnt: got %b, required 0", gnt); end
    cmp++; if (r_valid !== 1'b0) begin errs++; $display("FAIL reset_rvalid: got %b, required 0", r_valid); end
    cmp++; if (r_data !== 32'h0 || r_id !== 20'h0) begin
      errs++; $display("FAIL reset_rdata_rid: got %h/%h, required 0/0", r_data, r_id); end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    cmp++; if (gnt !== 1'b1) begin errs++; $display("FAIL reset_first_gnt: got %b, required 1", gnt); end
  endtask

  task automatic test_write_read();
    int a;
    rsp_t e, g;
    issue(0, 0, 13'h010, 4'hF, 32'hDEADBEEF, 20'h0, 0, a);
    issue(1, 0, 13'h010, 4'h0, 32'h0, 20'h5, 0, a);
    issue(0, 0, 13'h020, 4'hF, 32'h11223344, 20'h0, 0, a);
    issue(0, 0, 13'h020, 4'b0101, 32'hAABBCCDD, 20'h0, 0, a);
    issue(0, 0, 13'h020, 4'h0, 32'h55555555, 20'h0, 0, a);
    issue(1, 0, 13'h020, 4'h0, 32'h0, 20'h6, 0, a);
    drain();
    cmp++; if (exp_q.size() != 2 || exp_q[1].d !== 32'h11BB33DD || exp_q[0].d !== 32'hDEADBEEF) begin
      errs++; $display("FAIL wr_model_sanity: model holds %0d entries, required 2 with DEADBEEF/11BB33DD", exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); cmp++;
      if (got_q.size() == 0) begin errs++; $display("FAIL wr_rd_missing: no response, required data=%h id=%h", e.d, e.id); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errs++; $display("FAIL wr_rd: got cyc=%0d data=%h id=%h err=%b, required cyc=%0d data=%h id=%h err=%b",
                                           g.cyc, g.d, g.id, g.err, e.cyc, e.d, e.id, e.err); end
      end
    end
    cmp++; if (got_q.size() != 0) begin errs++; $display("FAIL wr_rd_extra: %0d unexpected responses, required 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_test_and_set();
    int a;
    rsp_t e, g;
    issue(0, 0, 13'h030, 4'hF, 32'h0, 20'h0, 0, a);
    issue(1, 1, 13'h030, 4'h0, 32'h0, 20'h9, 0, a);
    cmp++; if (gnt !== 1'b0) begin errs++; $display("FAIL ts_gnt_low: got %b, required 0", gnt); end
    @(posedge clk); #1;
    cmp++; if (gnt !== 1'b1) begin errs++; $display("FAIL ts_gnt_back: got %b, required 1", gnt); end
    issue(1, 0, 13'h030, 4'h0, 32'h0, 20'hA, 0, a);
    // ts_i with a write is just a write
    issue(0, 1, 13'h034, 4'hF, 32'h0BAD_F00D, 20'h0, 0, a);
    cmp++; if (gnt !== 1'b1) begin errs++; $display("FAIL ts_write_gnt: got %b, required 1", gnt); end
    issue(1, 0, 13'h034, 4'h0, 32'h0, 20'hB, 0, a);
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); cmp++;
      if (got_q.size() == 0) begin errs++; $display("FAIL ts_missing: no response, required data=%h id=%h", e.d, e.id); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errs++; $display("FAIL ts: got cyc=%0d data=%h id=%h err=%b, required cyc=%0d data=%h id=%h err=%b",
                                           g.cyc, g.d, g.id, g.err, e.cyc, e.d, e.id, e.err); end
      end
    end
    cmp++; if (got_q.size() != 0) begin errs++; $display("FAIL ts_extra: %0d unexpected responses, required 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_back_to_back();
    int a, first, last;
    rsp_t e, g;
    for (int k = 0; k < 4; k++) issue(0, 0, 13'(13'h100 + 4*k), 4'hF, 32'(k + 1), 20'h0, 0, a);
    for (int k = 0; k < 4; k++) begin
      issue(1, 0, 13'(13'h100 + 4*k), 4'h0, 32'h0, 20'(k), 0, a);
      if (k == 0) first = a;
      last = a;
    end
    drain();
    cmp++; if (last - first != 3) begin errs++; $display("FAIL b2b_accept_span: got %0d, required 3", last - first); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); cmp++;
      if (got_q.size() == 0) begin errs++; $display("FAIL b2b_missing: no response, required data=%h id=%h", e.d, e.id); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errs++; $display("FAIL b2b: got cyc=%0d data=%h id=%h err=%b, required cyc=%0d data=%h id=%h err=%b",
                                           g.cyc, g.d, g.id, g.err, e.cyc, e.d, e.id, e.err); end
      end
    end
    cmp++; if (got_q.size() != 0) begin errs++; $display("FAIL b2b_extra: %0d unexpected responses, required 0", got_q.size()); got_q.delete(); end
    cmp++; if (r_valid !== 1'b0 || r_data !== 32'h4 || r_id !== 20'h3) begin
      errs++; $display("FAIL b2b_hold: got valid=%b data=%h id=%h, required 0/4/3", r_valid, r_data, r_id); end
  endtask

  task automatic test_reset_mid();
    int a;
    rsp_t e, g;
    issue(0, 0, 13'h040, 4'hF, 32'h12345678, 20'h0, 0, a);
    issue(1, 0, 13'h040, 4'h0, 32'h0, 20'h7, 0, a);
    rst = 1'b1; exp_q.delete();
    @(negedge clk);
    cmp++; if (gnt !== 1'b0) begin errs++; $display("FAIL mid_reset_gnt: got %b, required 0", gnt); end
    cmp++; if (r_valid !== 1'b0 || r_data !== 32'h0 || r_id !== 20'h0 || r_err !== 1'b0) begin
      errs++; $display("FAIL mid_reset_outputs: got %b/%h/%h/%b, required 0/0/0/0", r_valid, r_data, r_id, r_err); end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    cmp++; if (gnt !== 1'b1) begin errs++; $display("FAIL mid_release_gnt: got %b, required 1", gnt); end
    drain();
    cmp++; if (got_q.size() != 0) begin errs++; $display("FAIL mid_dropped: %0d responses after reset, required 0", got_q.size()); got_q.delete(); end
    // reset landing in the TS set cycle leaves the word untouched
    issue(0, 0, 13'h050, 4'hF, 32'hA5A5A5A5, 20'h0, 0, a);
    issue(1, 1, 13'h050, 4'h0, 32'h0, 20'h1, 0, a);
    rst = 1'b1; exp_q.delete(); mem_m[13'h050 >> 2] = 32'hA5A5A5A5;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    issue(1, 0, 13'h050, 4'h0, 32'h0, 20'h2, 0, a);
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); cmp++;
      if (got_q.size() == 0) begin errs++; $display("FAIL mid_ts_missing: no response, required data=%h id=%h", e.d, e.id); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errs++; $display("FAIL mid_ts: got cyc=%0d data=%h id=%h err=%b, required cyc=%0d data=%h id=%h err=%b",
                                           g.cyc, g.d, g.id, g.err, e.cyc, e.d, e.id, e.err); end
      end
    end
    cmp++; if (got_q.size() != 0) begin errs++; $display("FAIL mid_ts_extra: %0d unexpected responses, required 0", got_q.size()); got_q.delete(); end
  endtask

`ifdef TCDM_BANK_PARITY_EN
  task automatic test_parity();
    int a;
    rsp_t g;
    issue(0, 0, 13'h060, 4'hF, 32'hCAFEF00D, 20'h0, 1, a);
    issue(1, 0, 13'h060, 4'h0, 32'h0, 20'h3, 0, a);
    issue(0, 0, 13'h060, 4'hF, 32'hCAFEF00D, 20'h0, 0, a);
    issue(1, 0, 13'h060, 4'h0, 32'h0, 20'h4, 0, a);
    drain();
    exp_q.delete();
    cmp++; if (got_q.size() != 2) begin errs++; $display("FAIL par_count: got %0d responses, required 2", got_q.size()); end
    else begin
      g = got_q.pop_front(); cmp++;
      if (g.err !== 1'b1 || g.d !== 32'hCAFEF00D) begin errs++; $display("FAIL par_inject: got err=%b data=%h, required 1/cafef00d", g.err, g.d); end
      g = got_q.pop_front(); cmp++;
      if (g.err !== 1'b0 || g.d !== 32'hCAFEF00D) begin errs++; $display("FAIL par_clean: got err=%b data=%h, required 0/cafef00d", g.err, g.d); end
    end
    got_q.delete();
  endtask
`endif

  task automatic test_random();
    int a;
    rsp_t e, g;
    logic [12:0] pool [8];
    for (int k = 0; k < 8; k++) begin
      pool[k] = {11'($urandom_range(0, 2047)), 2'($urandom)};
      issue(0, 0, pool[k], 4'hF, $urandom, 20'h0, 0, a);
    end
    for (int n = 0; n < 120; n++) begin
      int r = $urandom_range(0, 99);
      logic [12:0] ad = pool[$urandom_range(0, 7)];
      if (r < 40) issue(0, $urandom_range(0, 3) == 0, ad, 4'($urandom), $urandom, 20'h0, $urandom_range(0, 3) == 0, a);
      else if (r < 85) issue(1, 0, ad, 4'($urandom), 32'h0, 20'($urandom), 0, a);
      else if (r < 93) issue(1, 1, ad, 4'h0, 32'h0, 20'($urandom), 0, a);
      else begin @(posedge clk); #1; end
    end
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); cmp++;
      if (got_q.size() == 0) begin errs++; $display("FAIL rand_missing: no response, required data=%h id=%h", e.d, e.id); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errs++; $display("FAIL rand: got cyc=%0d data=%h id=%h err=%b, required cyc=%0d data=%h id=%h err=%b",
                                           g.cyc, g.d, g.id, g.err, e.cyc, e.d, e.id, e.err); end
      end
    end
    cmp++; if (got_q.size() != 0) begin errs++; $display("FAIL rand_extra: %0d unexpected responses, required 0", got_q.size()); got_q.delete(); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_test_and_set();
    test_back_to_back();
    test_reset_mid();
`ifdef TCDM_BANK_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
